flit_packet_tx: RTL and testbench

- Transmit-side packetiser, sitting between the node's message source and the router injection port.
- Accepts one packet descriptor plus N payload words and emits a HEAD flit followed by N data flits, the last one typed TAIL.
- Generates flit_id (packet_id, flit_num) and inserts the 8-bit checksum into every flit it emits.
- It is the sender counterpart of the receive-side checksum check: every emitted flit must validate there (is_valid=1).

---
 rtl/flit_packet_tx_pkg.sv | 60 ++++++
 rtl/flit_packet_tx_if.sv | 31 +++
 rtl/flit_packet_tx_insert_checksum.sv | 16 +
 rtl/flit_packet_tx.sv | 160 ++++++++++++++++
 tb/tb_flit_packet_tx.sv | 319 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/flit_packet_tx_pkg.sv
// Shared flit types, widths and checksum helper for the transmit packetiser.
package flit_packet_tx_pkg;

    localparam int unsigned NODE_ID_W   = 4;
    localparam int unsigned PACKET_ID_W = 4;
    localparam int unsigned FLIT_NUM_W  = 6;
    localparam int unsigned VERSION_W   = 4;
    localparam int unsigned PAYLOAD_W   = 32;
    localparam int unsigned CHECKSUM_W  = 8;

    typedef logic [NODE_ID_W-1:0]   node_id_t;
    typedef logic [PACKET_ID_W-1:0] packet_id_t;
    typedef logic [FLIT_NUM_W-1:0]  flit_num_t;
    typedef logic [PAYLOAD_W-1:0]   payload_t;
    typedef logic [CHECKSUM_W-1:0]  checksum_t;

    typedef enum logic [1:0] {
        NOPE = 2'd0,
        HEAD = 2'd1,
        BODY = 2'd2,
        TAIL = 2'd3
    } flittype_t;

    typedef struct packed {
        logic [VERSION_W-1:0] version;
        flittype_t            flittype;
        node_id_t             src_id;
        node_id_t             dst_id;
        packet_id_t           packet_id;
        flit_num_t            flit_num;
    } header_t;

    typedef struct packed {
        header_t   header;
        payload_t  payload;
        checksum_t checksum;
    } flit_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HEAD = 2'd1,
        ST_BODY = 2'd2
    } tx_state_t;

    localparam int unsigned HDR_W      = $bits(header_t);
    localparam int unsigned BODY_BYTES = (HDR_W + PAYLOAD_W) / 8;

    // Two's complement of the byte sum, so the whole flit sums to zero.
    function automatic checksum_t calc_checksum(header_t header, payload_t payload);
        logic [HDR_W+PAYLOAD_W-1:0] bits;
        checksum_t                  sum;
        bits = {header, payload};
        sum  = '0;
        for (int unsigned i = 0; i < BODY_BYTES; i++) begin
            sum = sum + bits[i*8 +: 8];
        end
        return checksum_t'(8'd0 - sum);
    endfunction

endpackage

// File: rtl/flit_packet_tx_if.sv
// Descriptor, payload and flit handshake bundle for the transmit packetiser.
interface flit_packet_tx_if #(
    parameter int unsigned LEN_W = 4
);
    import flit_packet_tx_pkg::*;

    logic             pkt_valid;
    logic             pkt_ready;
    node_id_t         pkt_src_id;
    node_id_t         pkt_dst_id;
    logic [LEN_W-1:0] pkt_len;
    logic             data_valid;
    logic             data_ready;
    payload_t         data_payload;
    logic             flit_valid;
    logic             flit_ready;
    flit_t            flit_out;

    modport master (
        output pkt_valid, pkt_src_id, pkt_dst_id, pkt_len,
        output data_valid, data_payload, flit_ready,
        input  pkt_ready, data_ready, flit_valid, flit_out
    );

    modport slave (
        input  pkt_valid, pkt_src_id, pkt_dst_id, pkt_len,
        input  data_valid, data_payload, flit_ready,
        output pkt_ready, data_ready, flit_valid, flit_out
    );

endinterface

// File: rtl/flit_packet_tx_insert_checksum.sv
// Combinational flit assembly: header and payload in, flit with checksum out.
module insert_checksum_comb
    import flit_packet_tx_pkg::*;
(
    input  header_t  header,
    input  payload_t payload,
    output flit_t    flit_c
);

    always_comb begin
        flit_c.header   = header;
        flit_c.payload  = payload;
        flit_c.checksum = calc_checksum(header, payload);
    end

endmodule

// File: rtl/flit_packet_tx.sv
// Transmit packetiser: one descriptor plus N payload words become HEAD + N flits,
// the last typed TAIL, each carrying a checksum, through a single output register.
module flit_packet_tx
    import flit_packet_tx_pkg::*;
#(
    parameter int unsigned MAX_LEN = 15,
    parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1),
    parameter int unsigned VERSION = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    flit_packet_tx_if.slave bus,
    output logic            busy,
    output logic            err_len
);

    tx_state_t        state_q;
    tx_state_t        state_d;
    node_id_t         src_q;
    node_id_t         dst_q;
    logic [LEN_W-1:0] len_q;
    flit_num_t        fnum_q;
    packet_id_t       pid_q;
    logic             flit_valid_q;
    flit_t            flit_q;
    logic             err_len_q;

    logic             load_ok_c;
    logic             len_ok_c;
    logic             pkt_ready_c;
    logic             data_ready_c;
    logic             accept_c;
    logic             err_c;
    logic             load_head_c;
    logic             load_data_c;
    logic             tail_c;
    logic [LEN_W-1:0] head_len_c;
    header_t          hdr_c;
    payload_t         pay_c;
    flit_t            flit_c;

    assign load_ok_c = !flit_valid_q || bus.flit_ready;
    assign len_ok_c  = (bus.pkt_len != '0) && (32'(bus.pkt_len) <= MAX_LEN);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept_c)             state_d = load_head_c ? ST_BODY : ST_HEAD;
            ST_HEAD: if (load_head_c)          state_d = ST_BODY;
            ST_BODY: if (load_data_c && tail_c) state_d = ST_IDLE;
            default:                           state_d = ST_IDLE;
        endcase
    end

    // Handshake decode and next-flit header; in IDLE the HEAD is built straight
    // from the descriptor so it appears the cycle after acceptance.
    always_comb begin
        pkt_ready_c       = 1'b0;
        data_ready_c      = 1'b0;
        accept_c          = 1'b0;
        err_c             = 1'b0;
        load_head_c       = 1'b0;
        load_data_c       = 1'b0;
        tail_c            = 1'b0;
        head_len_c        = len_q;
        pay_c             = '0;
        hdr_c             = '0;
        hdr_c.version     = VERSION_W'(VERSION);
        hdr_c.packet_id   = pid_q;
        hdr_c.src_id      = src_q;
        hdr_c.dst_id      = dst_q;
        case (state_q)
            ST_IDLE: begin
                pkt_ready_c  = 1'b1;
                accept_c     = bus.pkt_valid && len_ok_c;
                err_c        = bus.pkt_valid && !len_ok_c;
                load_head_c  = accept_c && load_ok_c;
                head_len_c   = bus.pkt_len;
                hdr_c.src_id = bus.pkt_src_id;
                hdr_c.dst_id = bus.pkt_dst_id;
            end
            ST_HEAD: load_head_c = load_ok_c;
            ST_BODY: begin
                data_ready_c = load_ok_c;
                load_data_c  = bus.data_valid && load_ok_c;
            end
            default: ;
        endcase
        if (load_head_c) begin
            hdr_c.flittype = HEAD;
            hdr_c.flit_num = '0;
            pay_c          = PAYLOAD_W'(head_len_c);
        end else if (load_data_c) begin
            tail_c         = (fnum_q == FLIT_NUM_W'(len_q));
            hdr_c.flittype = tail_c ? TAIL : BODY;
            hdr_c.flit_num = fnum_q;
            pay_c          = bus.data_payload;
        end
    end

    insert_checksum_comb u_insert_checksum (
        .header  (hdr_c),
        .payload (pay_c),
        .flit_c  (flit_c)
    );

    // Packet context, counters and the output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_q        <= '0;
            dst_q        <= '0;
            len_q        <= '0;
            fnum_q       <= '0;
            pid_q        <= '0;
            flit_valid_q <= 1'b0;
            flit_q       <= '0;
            err_len_q    <= 1'b0;
        end else begin
            err_len_q <= err_c;
            if (accept_c) begin
                src_q  <= bus.pkt_src_id;
                dst_q  <= bus.pkt_dst_id;
                len_q  <= bus.pkt_len;
                fnum_q <= '0;
            end
            if (load_head_c) begin
                fnum_q <= FLIT_NUM_W'(1);
            end else if (load_data_c) begin
                fnum_q <= fnum_q + FLIT_NUM_W'(1);
            end
            if (load_data_c && tail_c) begin
                pid_q <= pid_q + PACKET_ID_W'(1);
            end
            if (load_head_c || load_data_c) begin
                flit_q       <= flit_c;
                flit_valid_q <= 1'b1;
            end else if (bus.flit_ready) begin
                flit_valid_q <= 1'b0;
            end
        end
    end

    assign bus.pkt_ready  = pkt_ready_c;
    assign bus.data_ready = data_ready_c;
    assign bus.flit_valid = flit_valid_q;
    assign bus.flit_out   = flit_q;
    assign err_len        = err_len_q;
    assign busy           = (state_q != ST_IDLE) || flit_valid_q;

endmodule

// File: tb/tb_flit_packet_tx.sv
// Randomised bench for flit_packet_tx against a queue-based packet model.
module tb_flit_packet_tx;
    import flit_packet_tx_pkg::*;

    localparam int MAX_LEN = 15;
    localparam int LEN_W   = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;
    logic err_len;

    always #5 clk = ~clk;

    flit_packet_tx_if #(.LEN_W(LEN_W)) bus ();

    flit_packet_tx #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .VERSION(0)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .busy    (busy),
        .err_len (err_len)
    );

    typedef struct {
        int src;
        int dst;
        int len;
    } desc_t;

    int          checks   = 0;
    int          failures = 0;
    desc_t       desc_q[$];
    logic [31:0] data_q[$];
    logic [63:0] exp_q[$];
    logic [63:0] seen_q[$];
    int          seen_cyc[$];
    int          ready_mode = 0;
    bit          dense      = 1'b1;
    bit          in_pkt     = 1'b0;
    int          m_src, m_dst, m_len, m_num;
    int          m_pid      = 0;
    bit          exp_err    = 1'b0;
    bit          due_v      = 1'b0;
    logic [63:0] due_flit;
    bit          stall_prev = 1'b0;
    logic [63:0] prev_flit;
    int          err_cnt    = 0;
    int          cyc        = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Flit as the receiver sees it: header fields, payload, then the byte that zeroes the sum.
    function automatic logic [63:0] make_flit(input int ftype, input int src, input int dst,
                                              input int pid, input int num, input logic [31:0] pay);
        int hv;
        int s;
        hv = ftype * (1 << 18) + src * (1 << 14) + dst * (1 << 10) + pid * 64 + num;
        s  = ((hv >> 16) & 255) + ((hv >> 8) & 255) + (hv & 255)
           + int'(pay[31:24]) + int'(pay[23:16]) + int'(pay[15:8]) + int'(pay[7:0]);
        return {24'(hv), pay, 8'((256 - (s % 256)) % 256)};
    endfunction

    function automatic int bytesum(input logic [63:0] f);
        int s = 0;
        for (int i = 0; i < 8; i++) s += int'(f[i*8 +: 8]);
        return s % 256;
    endfunction

    // Single compare/drive process: check at negedge, drive, then log handshakes.
    initial begin
        desc_t       d;
        logic [63:0] f;
        logic [63:0] fo;
        bus.pkt_valid    = 1'b0;
        bus.pkt_src_id   = '0;
        bus.pkt_dst_id   = '0;
        bus.pkt_len      = '0;
        bus.data_valid   = 1'b0;
        bus.data_payload = '0;
        bus.flit_ready   = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                exp_q.delete();
                in_pkt         = 1'b0;
                m_pid          = 0;
                exp_err        = 1'b0;
                due_v          = 1'b0;
                stall_prev     = 1'b0;
                bus.pkt_valid  = 1'b0;
                bus.data_valid = 1'b0;
                continue;
            end
            fo = bus.flit_out;
            chk("err_len", 64'(err_len), 64'(exp_err));
            if (err_len) err_cnt++;
            chk("busy", 64'(busy), 64'(in_pkt || exp_q.size() > 0));
            chk("pkt_ready", 64'(bus.pkt_ready), 64'(!in_pkt));
            if (due_v) begin
                chk("load_valid", 64'(bus.flit_valid), 64'(1));
                chk("load_flit", fo, due_flit);
            end
            if (stall_prev) begin
                chk("stall_valid", 64'(bus.flit_valid), 64'(1));
                chk("stall_hold", fo, prev_flit);
            end
            if (bus.flit_valid) chk("byte_sum", 64'(bytesum(fo)), 64'(0));

            case (ready_mode)
                0:       bus.flit_ready = 1'b1;
                1:       bus.flit_ready = ~bus.flit_ready;
                default: bus.flit_ready = 1'($urandom_range(0, 1));
            endcase
            if (desc_q.size() > 0) begin
                bus.pkt_valid  = 1'b1;
                bus.pkt_src_id = node_id_t'(desc_q[0].src);
                bus.pkt_dst_id = node_id_t'(desc_q[0].dst);
                bus.pkt_len    = LEN_W'(desc_q[0].len);
            end else begin
                bus.pkt_valid  = 1'b0;
            end
            if (data_q.size() > 0 && (dense || $urandom_range(0, 2) != 0)) begin
                bus.data_valid   = 1'b1;
                bus.data_payload = data_q[0];
            end else begin
                bus.data_valid   = 1'b0;
                bus.data_payload = $urandom;
            end
            #1;
            due_v      = 1'b0;
            exp_err    = 1'b0;
            fo         = bus.flit_out;
            stall_prev = bus.flit_valid && !bus.flit_ready;
            prev_flit  = fo;
            if (bus.flit_valid && bus.flit_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_flit", fo, 64'(0) - 64'(1) ^ fo);
                end else begin
                    chk("flit", fo, exp_q.pop_front());
                end
                seen_q.push_back(fo);
                seen_cyc.push_back(cyc);
            end
            if (!in_pkt || stall_prev) chk("data_ready_low", 64'(bus.data_ready), 64'(0));
            if (bus.pkt_valid && bus.pkt_ready) begin
                d = desc_q.pop_front();
                if (d.len >= 1 && d.len <= MAX_LEN) begin
                    f = make_flit(1, d.src, d.dst, m_pid, 0, 32'(d.len));
                    if (exp_q.size() == 0) begin
                        due_v    = 1'b1;
                        due_flit = f;
                    end
                    exp_q.push_back(f);
                    in_pkt = 1'b1;
                    m_src  = d.src;
                    m_dst  = d.dst;
                    m_len  = d.len;
                    m_num  = 0;
                end else begin
                    exp_err = 1'b1;
                end
            end
            if (bus.data_valid && bus.data_ready) begin
                if (!in_pkt) begin
                    chk("data_outside_packet", 64'(1), 64'(0));
                end else begin
                    m_num++;
                    void'(data_q.pop_front());
                    f = make_flit((m_num == m_len) ? 3 : 2, m_src, m_dst, m_pid, m_num, bus.data_payload);
                    exp_q.push_back(f);
                    due_v    = 1'b1;
                    due_flit = f;
                    if (m_num == m_len) begin
                        in_pkt = 1'b0;
                        m_pid  = (m_pid + 1) % 16;
                    end
                end
            end
        end
    end

    task automatic send_pkt(input int src, input int dst, input int len, input bit zero_data);
        desc_t d;
        d.src = src;
        d.dst = dst;
        d.len = len;
        desc_q.push_back(d);
        for (int i = 0; i < len; i++) data_q.push_back(zero_data ? 32'h0 : 32'($urandom));
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(posedge clk);
            done = desc_q.size() == 0 && data_q.size() == 0 && exp_q.size() == 0 && !in_pkt;
        end
        chk("idle_timeout", 64'(done), 64'(1));
        repeat (3) @(posedge clk);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          b;
        int          e0;
        bit          hit;
        logic [63:0] f;

        repeat (2) @(posedge clk);
        #2;
        chk("rst_flit_valid", 64'(bus.flit_valid), 64'(0));
        chk("rst_flit_out", bus.flit_out, 64'(0));
        chk("rst_pkt_ready", 64'(bus.pkt_ready), 64'(1));
        chk("rst_data_ready", 64'(bus.data_ready), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_err_len", 64'(err_len), 64'(0));
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Illegal length: one error pulse, nothing emitted, packet_id untouched.
        e0 = err_cnt;
        b  = seen_q.size();
        send_pkt(0, 0, 0, 1'b0);
        wait_idle();
        chk("t2_err_pulses", 64'(err_cnt - e0), 64'(1));
        chk("t2_no_flit", 64'(seen_q.size()), 64'(b));

        // Single-word packet, values worked out by hand.
        b = seen_q.size();
        send_pkt(1, 2, 1, 1'b1);
        wait_idle();
        chk("t1_count", 64'(seen_q.size() - b), 64'(2));
        chk("t1_head", seen_q[b], 64'h04480000000001B3);
        chk("t1_tail", seen_q[b+1], 64'h0C480100000000AB);

        // Back-to-back, always ready.
        b = seen_q.size();
        send_pkt(3, 4, 3, 1'b0);
        wait_idle();
        chk("t3_span", 64'(seen_cyc[b+3] - seen_cyc[b]), 64'(3));
        for (int i = 0; i < 4; i++) begin
            f = seen_q[b+i];
            chk("t3_flit_num", 64'(f[45:40]), 64'(i));
            chk("t3_pid", 64'(f[49:46]), 64'(1));
        end
        send_pkt(5, 6, 2, 1'b0);
        wait_idle();
        f = seen_q[b+4];
        chk("t3_pid_next", 64'(f[49:46]), 64'(2));

        // Downstream toggling ready.
        ready_mode = 1;
        b = seen_q.size();
        send_pkt(7, 8, 3, 1'b0);
        send_pkt(9, 10, 3, 1'b0);
        wait_idle();
        chk("t4_count", 64'(seen_q.size() - b), 64'(8));

        // Random traffic until packet_id wraps.
        ready_mode = 2;
        dense      = 1'b0;
        for (int n = 0; n < 20 && m_pid != 0; n++) begin
            send_pkt($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(1, MAX_LEN), 1'b0);
            wait_idle();
        end
        f = seen_q[seen_q.size()-1];
        chk("t5_last_pid", 64'(f[49:46]), 64'(15));
        b = seen_q.size();
        send_pkt(2, 3, 1, 1'b0);
        wait_idle();
        f = seen_q[b];
        chk("t5_wrap_pid", 64'(f[49:46]), 64'(0));

        // Reset in the middle of a body.
        ready_mode = 0;
        dense      = 1'b1;
        send_pkt(1, 1, 5, 1'b0);
        b   = seen_q.size();
        hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            @(posedge clk);
            hit = seen_q.size() >= b + 3;
        end
        chk("t6_reach_body", 64'(hit), 64'(1));
        #2;
        rst_n = 1'b0;
        desc_q.delete();
        data_q.delete();
        #1;
        chk("t6_async_valid", 64'(bus.flit_valid), 64'(0));
        chk("t6_async_busy", 64'(busy), 64'(0));
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        b = seen_q.size();
        send_pkt(4, 5, 2, 1'b0);
        wait_idle();
        f = seen_q[b];
        chk("t6_head_type", 64'(f[59:58]), 64'(1));
        chk("t6_head_pid", 64'(f[49:46]), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
